ball_engine: RTL and testbench

Game-logic stage directly upstream of the VGA renderer. Once per video frame it moves the ball and resolves collisions against the walls, the paddle and the 12-block field. It drives ball_x, ball_y, erase_enable and erase_pos into the renderer, and takes the renderer's hor_count and ver_count as its frame timebase. Its block geometry table equals the renderer's layout exactly:
- Blocks 0-4: y=40, x=40+120*i.
- Blocks 5-9: y=90, x=40+120*(i-5).
- Block 10: x=160, y=140.
- Block 11: x=400, y=140.
- All blocks are 80 wide and 30 high, with inclusive bounds x..x+80 and y..y+30.

---
 rtl/ball_engine.sv | 134 +++++++++++++
 tb/tb_ball_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// ball_engine: once-per-frame ball motion with wall, paddle and block collisions.
// The block table below must stay identical to the renderer's layout.
module ball_engine #(
    parameter int BALL_SIZE  = 7,
    parameter int SPEED      = 2,
    parameter int PADDLE_Y   = 441,
    parameter int PADDLE_W   = 100,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int NUM_BLOCKS = 12
) (
    input  logic       CLK_25MH,
    input  logic       reset,
    input  logic [9:0] hor_count,
    input  logic [9:0] ver_count,
    input  logic [9:0] paddle_pos,
    input  logic       launch,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       erase_enable,
    output logic [5:0] erase_pos,
    output logic       ball_lost,
    output logic [3:0] blocks_left,
    output logic       win
);
    localparam logic [10:0] B         = 11'(BALL_SIZE);
    localparam logic [10:0] S         = 11'(SPEED);
    localparam logic [10:0] X_MAX     = 11'(SCREEN_W - 1 - BALL_SIZE);
    localparam logic [10:0] Y_BOT     = 11'(SCREEN_H - 1);
    localparam logic [10:0] PY        = 11'(PADDLE_Y);
    localparam logic [10:0] PY_BOT    = 11'(PADDLE_Y + 8);
    localparam logic [10:0] PW        = 11'(PADDLE_W);
    localparam logic [10:0] SERVE_OFF = 11'(PADDLE_W / 2 - (BALL_SIZE + 1) / 2);
    localparam logic [9:0]  Y_SERVE   = 10'(PADDLE_Y - BALL_SIZE - 2);
    localparam logic [10:0] Y_BOUNCE  = 11'(PADDLE_Y - BALL_SIZE - 1);

    typedef enum logic [2:0] {SERVE, WAIT, MOVE, PADDLE, SCAN, COMMIT, LOST, WIN} state_t;

    state_t                state;
    logic                  dx_pos, dy_down;
    logic [10:0]           nx, ny, bx, by, mx, my, sx, xx, yy, pad;
    logic [3:0]            k;
    logic [NUM_BLOCKS-1:0] alive;
    logic                  tick, mx_flip, my_flip, lost, phit, bhit;
    logic [9:0]            serve_x;

    always_comb begin
        xx = {1'b0, ball_x};
        yy = {1'b0, ball_y};
        pad = {1'b0, paddle_pos};
        sx = pad + SERVE_OFF;
        serve_x = sx > X_MAX ? X_MAX[9:0] : sx[9:0];
        tick = hor_count == 10'd0 && ver_count == 10'(SCREEN_H);
        mx_flip = dx_pos ? xx + S > X_MAX : xx < S;
        mx = mx_flip ? (dx_pos ? X_MAX : 11'd0) : (dx_pos ? xx + S : xx - S);
        my_flip = !dy_down && yy < S;
        my = my_flip ? 11'd0 : (dy_down ? yy + S : yy - S);
        lost = dy_down && my + B >= Y_BOT;
        phit = dy_down && ny + B >= PY && ny <= PY_BOT && nx + B > pad && nx < pad + PW;
        bx = k < 4'd5  ? 11'd40 + 11'd120 * 11'(k) :
             k < 4'd10 ? 11'd40 + 11'd120 * 11'(k - 4'd5) :
             k == 4'd10 ? 11'd160 : 11'd400;
        by = k < 4'd5 ? 11'd40 : k < 4'd10 ? 11'd90 : 11'd140;
        bhit = alive[k] && nx <= bx + 11'd80 && nx + B >= bx && ny <= by + 11'd30 && ny + B >= by;
    end

    // nx/ny hold the candidate position from MOVE until COMMIT publishes it
    always_ff @(posedge CLK_25MH) begin
        erase_enable <= 1'b0;
        ball_lost <= 1'b0;
        if (reset) begin
            state <= SERVE;
            ball_x <= serve_x;
            ball_y <= Y_SERVE;
            dx_pos <= 1'b1;
            dy_down <= 1'b0;
            alive <= '1;
            blocks_left <= 4'(NUM_BLOCKS);
            erase_pos <= 6'd0;
            win <= 1'b0;
            nx <= 11'd0;
            ny <= 11'd0;
            k <= 4'd0;
        end else begin
            case (state)
                SERVE: if (tick) begin
                    ball_x <= serve_x;
                    ball_y <= Y_SERVE;
                    if (launch) begin
                        dx_pos <= 1'b1;
                        dy_down <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: if (tick) state <= MOVE;
                MOVE: begin
                    nx <= mx;
                    ny <= my;
                    dx_pos <= dx_pos ^ mx_flip;
                    dy_down <= dy_down ^ my_flip;
                    ball_lost <= lost;
                    state <= lost ? LOST : PADDLE;
                end
                PADDLE: begin
                    k <= 4'd0;
                    if (phit) begin
                        dy_down <= 1'b0;
                        ny <= Y_BOUNCE;
                    end
                    state <= phit ? COMMIT : SCAN;
                end
                SCAN: begin
                    if (bhit) begin
                        alive[k] <= 1'b0;
                        dy_down <= !dy_down;
                        erase_enable <= 1'b1;
                        erase_pos <= {2'b00, k};
                        blocks_left <= blocks_left - 4'd1;
                    end
                    k <= k + 4'd1;
                    state <= bhit || k == 4'(NUM_BLOCKS - 1) ? COMMIT : SCAN;
                end
                COMMIT: begin
                    ball_x <= nx[9:0];
                    ball_y <= ny[9:0];
                    win <= blocks_left == 4'd0;
                    state <= blocks_left == 4'd0 ? WIN : WAIT;
                end
                LOST: state <= SERVE;
                WIN: state <= WIN;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: random play against a frame-level game model; a monitor
// pops one expected frame outcome per frame and compares it with the DUT.
module tb_ball_engine;
    localparam int FL = 20;

    logic       CLK_25MH = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hor_count = 10'd1000;
    logic [9:0] ver_count = 10'd0;
    logic [9:0] paddle_pos = 10'd200;
    logic       launch = 1'b0;
    logic [9:0] ball_x, ball_y;
    logic       erase_enable, ball_lost, win;
    logic [5:0] erase_pos;
    logic [3:0] blocks_left;

    ball_engine dut (
        .CLK_25MH(CLK_25MH), .reset(reset), .hor_count(hor_count), .ver_count(ver_count),
        .paddle_pos(paddle_pos), .launch(launch), .ball_x(ball_x), .ball_y(ball_y),
        .erase_enable(erase_enable), .erase_pos(erase_pos), .ball_lost(ball_lost),
        .blocks_left(blocks_left), .win(win)
    );

    always #20 CLK_25MH = ~CLK_25MH;

    typedef struct {
        int x, y, ep, lost, left, win;
    } exp_t;

    exp_t q[$];
    int   checks = 0, fails = 0;
    int   bx_t[12] = '{40, 160, 280, 400, 520, 40, 160, 280, 400, 520, 160, 400};
    int   by_t[12] = '{40, 40, 40, 40, 40, 90, 90, 90, 90, 90, 140, 140};

    // game model: mode 0 serve, 1 play, 2 won
    int   m_x, m_y, m_dx, m_dy, m_left, m_mode, m_ep, m_lost;
    bit   m_alive[12];
    int   pad;
    bit   lch;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    function automatic void model_reset(input int p);
        m_x = (p + 46 > 632) ? 632 : p + 46;
        m_y = 432;
        m_dx = 1;
        m_dy = -1;
        m_left = 12;
        m_mode = 0;
        foreach (m_alive[i]) m_alive[i] = 1'b1;
    endfunction

    function automatic void model_step(input int p, input bit l);
        int nx, ny;
        m_ep = -1;
        m_lost = 0;
        if (m_mode == 0) begin
            m_x = (p + 46 > 632) ? 632 : p + 46;
            m_y = 432;
            if (l) begin
                m_dx = 1;
                m_dy = -1;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            nx = m_x + 2 * m_dx;
            ny = m_y + 2 * m_dy;
            if (nx < 0) begin nx = 0; m_dx = 1; end
            if (nx > 632) begin nx = 632; m_dx = -1; end
            if (ny < 0) begin ny = 0; m_dy = 1; end
            if (m_dy > 0 && ny + 7 >= 479) begin
                m_lost = 1;
                m_mode = 0;
            end else begin
                if (m_dy > 0 && ny + 7 >= 441 && ny <= 449 && nx + 7 > p && nx < p + 100) begin
                    m_dy = -1;
                    ny = 433;
                end else begin
                    for (int j = 0; j < 12 && m_ep < 0; j++)
                        if (m_alive[j] && nx <= bx_t[j] + 80 && nx + 7 >= bx_t[j] &&
                            ny <= by_t[j] + 30 && ny + 7 >= by_t[j]) begin
                            m_alive[j] = 1'b0;
                            m_left--;
                            m_dy = -m_dy;
                            m_ep = j;
                        end
                end
                m_x = nx;
                m_y = ny;
                if (m_left == 0) m_mode = 2;
            end
        end
    endfunction

    task automatic frame(input bit tk);
        exp_t e;
        for (int c = 0; c < FL; c++) begin
            @(posedge CLK_25MH);
            #1;
            hor_count = 10'(c);
            ver_count = tk ? 10'd480 : 10'd481;
            if (c == 0) begin
                paddle_pos = 10'(pad);
                launch = lch;
                m_ep = -1;
                m_lost = 0;
                if (tk) model_step(pad, lch);
                e.x = m_x; e.y = m_y; e.ep = m_ep; e.lost = m_lost;
                e.left = m_left; e.win = (m_mode == 2) ? 1 : 0;
                q.push_back(e);
            end
        end
    endtask

    task automatic do_reset(input int p);
        @(posedge CLK_25MH);
        #1;
        reset = 1'b1;
        paddle_pos = 10'(p);
        hor_count = 10'd1000;
        ver_count = 10'd0;
        launch = 1'b0;
        repeat (3) @(posedge CLK_25MH);
        #1;
        reset = 1'b0;
        model_reset(p);
    endtask

    initial begin : monitor
        int   n_er, n_lost, er_pos;
        exp_t e;
        n_er = 0;
        n_lost = 0;
        er_pos = -1;
        forever begin
            @(negedge CLK_25MH);
            if (reset) begin
                n_er = 0;
                n_lost = 0;
            end
            if (erase_enable) begin
                n_er++;
                er_pos = int'(erase_pos);
            end
            if (ball_lost) n_lost++;
            if (hor_count == 10'(FL - 1) && q.size() > 0) begin
                e = q.pop_front();
                chk("ball_x", int'(ball_x), e.x);
                chk("ball_y", int'(ball_y), e.y);
                chk("erase_pulses", n_er, e.ep >= 0 ? 1 : 0);
                if (e.ep >= 0) chk("erase_pos", er_pos, e.ep);
                chk("ball_lost_pulses", n_lost, e.lost);
                chk("blocks_left", int'(blocks_left), e.left);
                chk("win", int'(win), e.win);
                n_er = 0;
                n_lost = 0;
                er_pos = -1;
            end
        end
    end

    initial begin : watchdog
        #(40 * 90000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin : stim
        int won;
        won = 0;
        pad = 200;
        lch = 1'b0;
        do_reset(200);
        frame(1'b0);
        frame(1'b1);
        lch = 1'b1;
        frame(1'b1);
        lch = 1'b0;
        frame(1'b1);
        frame(1'b1);
        for (int f = 0; f < 2000; f++) begin
            if ($urandom_range(0, 9) == 0) pad = $urandom_range(0, 586);
            else begin
                pad = m_x - int'($urandom_range(0, 92));
                if (pad < 0) pad = 0;
                if (pad > 586) pad = 586;
            end
            lch = $urandom_range(0, 2) == 0;
            frame(1'b1);
            if (m_mode == 2) won++;
            if (won > 4) break;
        end
        do_reset(int'($urandom_range(0, 586)));
        lch = 1'b0;
        frame(1'b0);
        frame(1'b1);
        @(negedge CLK_25MH);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
